i2c_transfer_sequencer: RTL and testbench

I2C_TRANSFER_SEQUENCER -- requirements
Module: i2c_transfer_sequencer

---
 rtl/i2c_seq_pkg.sv | 33 +++
 rtl/i2c_seq_timer.sv | 37 +++
 rtl/i2c_transfer_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_i2c_transfer_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// rtl/i2c_seq_pkg.sv - state encoding, engine command codes and cfg field positions
package i2c_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_ADDR,
      ST_FETCH,
      ST_WRITE,
      ST_READ,
      ST_PUSH,
      ST_STOP
   } state_e;

   localparam logic [2:0] CMD_START     = 3'd0;
   localparam logic [2:0] CMD_STOP      = 3'd1;
   localparam logic [2:0] CMD_WRITE     = 3'd2;
   localparam logic [2:0] CMD_READ_ACK  = 3'd3;
   localparam logic [2:0] CMD_READ_NACK = 3'd4;

   localparam int CFG_ADDR_LSB = 0;
   localparam int CFG_ADDR_MSB = 6;
   localparam int CFG_RW       = 7;
   localparam int CFG_CNT_LSB  = 8;
   localparam int CFG_CNT_MSB  = 11;
   localparam int CFG_EN       = 13;

   // A zero count field encodes a 16-byte transfer.
   function automatic logic [4:0] byte_count(input logic [3:0] cnt);
      return (cnt == 4'd0) ? 5'd16 : {1'b0, cnt};
   endfunction

endpackage

// File: rtl/i2c_seq_timer.sv
// rtl/i2c_seq_timer.sv - per-state wait counter; expired flags the limit-th counted cycle
module i2c_seq_timer #(
   parameter int TO_W = 14
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            en,
   input  logic [TO_W-1:0] limit,
   output logic            expired
);

   logic [TO_W-1:0] cnt_q;
   logic [TO_W-1:0] cnt_d;
   logic [TO_W-1:0] cnt_inc;

   assign cnt_inc = cnt_q + TO_W'(1);
   assign expired = en && (limit != '0) && (cnt_inc == limit);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/i2c_transfer_sequencer.sv
// rtl/i2c_transfer_sequencer.sv - sequences START/address/data/STOP commands to an I2C bit engine
module i2c_transfer_sequencer
   import i2c_seq_pkg::*;
#(
   parameter int TO_W = 14
) (
   input  logic            pclk,
   input  logic            preset,
   input  logic [13:0]     cfg,
   input  logic [TO_W-1:0] timeout,
   input  logic            tx_empty,
   input  logic [31:0]     tx_data,
   output logic            tx_rd_ena,
   input  logic            rx_full,
   output logic            rx_wr_ena,
   output logic [15:0]     rx_wdata,
   output logic [2:0]      eng_cmd,
   output logic [7:0]      eng_wdata,
   output logic            eng_valid,
   input  logic            eng_ready,
   input  logic            eng_done,
   input  logic            eng_ack,
   input  logic [7:0]      eng_rdata,
   output logic            busy,
   output logic            error,
   output logic            response_ack_nack,
   output logic [31:0]     current_data_tx
);

   state_e      state_q, state_d;
   logic        en_q, en_d, arm_q, arm_d;
   logic [6:0]  addr_q, addr_d;
   logic        rw_q, rw_d;
   logic [4:0]  rem_q, rem_d;
   logic [7:0]  rx_byte_q, rx_byte_d;
   logic        eng_valid_q, eng_valid_d;
   logic [2:0]  eng_cmd_q, eng_cmd_d;
   logic [7:0]  eng_wdata_q, eng_wdata_d;
   logic        tx_rd_ena_q, tx_rd_ena_d;
   logic        rx_wr_ena_q, rx_wr_ena_d;
   logic [15:0] rx_wdata_q, rx_wdata_d;
   logic        busy_q, busy_d;
   logic        error_q, error_d;
   logic        nack_q, nack_d;
   logic [31:0] cur_tx_q, cur_tx_d;
   logic        done_ok, start_edge, tmr_en, tmr_clr, tmr_expired;
   logic        unused_bits;

   assign unused_bits = ^{cfg[12], tx_data[31:8]};

   // A done pulse only belongs to the current command once it has been handed off.
   assign done_ok    = eng_done & ~eng_valid_q;
   // arm_q blocks an enable level that was already high coming out of reset.
   assign start_edge = cfg[CFG_EN] & ~en_q & arm_q & (state_q == ST_IDLE);
   assign tmr_en     = (state_q != ST_IDLE) && (state_q != ST_STOP);
   assign tmr_clr    = (state_d != state_q);

   i2c_seq_timer #(.TO_W(TO_W)) u_timer (
      .clk     (pclk),
      .rst     (preset),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .limit   (timeout),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d     = state_q;
      en_d        = cfg[CFG_EN];
      arm_d       = arm_q | ~cfg[CFG_EN];
      addr_d      = addr_q;
      rw_d        = rw_q;
      rem_d       = rem_q;
      rx_byte_d   = rx_byte_q;
      eng_valid_d = eng_valid_q & ~eng_ready;
      eng_cmd_d   = eng_cmd_q;
      eng_wdata_d = eng_wdata_q;
      tx_rd_ena_d = 1'b0;
      rx_wr_ena_d = 1'b0;
      rx_wdata_d  = rx_wdata_q;
      error_d     = error_q;
      nack_d      = nack_q;
      cur_tx_d    = cur_tx_q;

      case (state_q)
         ST_IDLE: if (start_edge) begin
            state_d = ST_START;
            addr_d  = cfg[CFG_ADDR_MSB:CFG_ADDR_LSB];
            rw_d    = cfg[CFG_RW];
            rem_d   = byte_count(cfg[CFG_CNT_MSB:CFG_CNT_LSB]);
            error_d = 1'b0;
            nack_d  = 1'b0;
         end
         ST_START: if (done_ok) state_d = ST_ADDR;
         ST_ADDR: if (done_ok) begin
            if (!eng_ack) begin
               nack_d  = 1'b1;
               state_d = ST_STOP;
            end else begin
               state_d = rw_q ? ST_READ : ST_FETCH;
            end
         end
         ST_FETCH: if (!tx_empty) begin
            tx_rd_ena_d = 1'b1;
            cur_tx_d    = {24'd0, tx_data[7:0]};
            state_d     = ST_WRITE;
         end
         ST_WRITE: if (done_ok) begin
            if (!eng_ack) begin
               nack_d  = 1'b1;
               state_d = ST_STOP;
            end else begin
               rem_d   = rem_q - 5'd1;
               state_d = (rem_q == 5'd1) ? ST_STOP : ST_FETCH;
            end
         end
         ST_READ: if (done_ok) begin
            rx_byte_d = eng_rdata;
            rem_d     = rem_q - 5'd1;
            state_d   = ST_PUSH;
         end
         ST_PUSH: if (!rx_full) begin
            rx_wr_ena_d = 1'b1;
            rx_wdata_d  = {1'b0, addr_q, rx_byte_q};
            state_d     = (rem_q == 5'd0) ? ST_STOP : ST_READ;
         end
         ST_STOP: if (done_ok) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Timeout wins over any same-cycle move; a coincident NACK keeps its flag.
      if (tmr_expired) begin
         error_d     = 1'b1;
         state_d     = ST_STOP;
         tx_rd_ena_d = 1'b0;
         rx_wr_ena_d = 1'b0;
         cur_tx_d    = cur_tx_q;
         rx_wdata_d  = rx_wdata_q;
      end

      // Every entry into an engine state loads a fresh command.
      if (state_d != state_q) begin
         eng_valid_d = 1'b1;
         eng_wdata_d = 8'd0;
         case (state_d)
            ST_START: eng_cmd_d = CMD_START;
            ST_ADDR: begin
               eng_cmd_d   = CMD_WRITE;
               eng_wdata_d = {addr_d, rw_d};
            end
            ST_WRITE: begin
               eng_cmd_d   = CMD_WRITE;
               eng_wdata_d = cur_tx_d[7:0];
            end
            ST_READ: eng_cmd_d = (rem_d == 5'd1) ? CMD_READ_NACK : CMD_READ_ACK;
            ST_STOP: eng_cmd_d = CMD_STOP;
            default: begin
               eng_valid_d = 1'b0;
               eng_wdata_d = eng_wdata_q;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q     <= ST_IDLE;
         en_q        <= 1'b0;
         arm_q       <= 1'b0;
         addr_q      <= '0;
         rw_q        <= 1'b0;
         rem_q       <= '0;
         rx_byte_q   <= '0;
         eng_valid_q <= 1'b0;
         eng_cmd_q   <= '0;
         eng_wdata_q <= '0;
         tx_rd_ena_q <= 1'b0;
         rx_wr_ena_q <= 1'b0;
         rx_wdata_q  <= '0;
         busy_q      <= 1'b0;
         error_q     <= 1'b0;
         nack_q      <= 1'b0;
         cur_tx_q    <= '0;
      end else begin
         state_q     <= state_d;
         en_q        <= en_d;
         arm_q       <= arm_d;
         addr_q      <= addr_d;
         rw_q        <= rw_d;
         rem_q       <= rem_d;
         rx_byte_q   <= rx_byte_d;
         eng_valid_q <= eng_valid_d;
         eng_cmd_q   <= eng_cmd_d;
         eng_wdata_q <= eng_wdata_d;
         tx_rd_ena_q <= tx_rd_ena_d;
         rx_wr_ena_q <= rx_wr_ena_d;
         rx_wdata_q  <= rx_wdata_d;
         busy_q      <= busy_d;
         error_q     <= error_d;
         nack_q      <= nack_d;
         cur_tx_q    <= cur_tx_d;
      end
   end

   assign eng_valid         = eng_valid_q;
   assign eng_cmd           = eng_cmd_q;
   assign eng_wdata         = eng_wdata_q;
   assign tx_rd_ena         = tx_rd_ena_q;
   assign rx_wr_ena         = rx_wr_ena_q;
   assign rx_wdata          = rx_wdata_q;
   assign busy              = busy_q;
   assign error             = error_q;
   assign response_ack_nack = nack_q;
   assign current_data_tx   = cur_tx_q;

endmodule

// File: tb/tb_i2c_transfer_sequencer.sv
// tb/tb_i2c_transfer_sequencer.sv - scoreboard bench with engine, TX and RX FIFO models
module tb_i2c_transfer_sequencer;
   import i2c_seq_pkg::*;

   localparam int TO_W = 14;

   logic            pclk = 1'b0;
   logic            preset;
   logic [13:0]     cfg;
   logic [TO_W-1:0] timeout;
   logic            tx_empty;
   logic [31:0]     tx_data;
   logic            tx_rd_ena;
   logic            rx_full;
   logic            rx_wr_ena;
   logic [15:0]     rx_wdata;
   logic [2:0]      eng_cmd;
   logic [7:0]      eng_wdata;
   logic            eng_valid;
   logic            eng_ready;
   logic            eng_done;
   logic            eng_ack;
   logic [7:0]      eng_rdata;
   logic            busy;
   logic            error;
   logic            response_ack_nack;
   logic [31:0]     current_data_tx;

   int errors = 0;
   int checks = 0;

   logic [10:0] exp_cmd_q[$];
   logic [15:0] exp_rx_q[$];
   logic [7:0]  tx_q[$];
   logic [7:0]  rd_q[$];

   int       tx_pops     = 0;
   int       cyc         = 0;
   int       pend_cnt    = 0;
   int       rd_fire_cyc = -100;
   int       wait_cyc    = 0;
   logic [2:0] pend_cmd  = 3'd0;
   bit       addr_phase    = 1'b0;
   bit       pend_is_addr  = 1'b0;
   bit       nack_addr     = 1'b0;
   bit       withhold_data = 1'b0;
   bit       hold_full     = 1'b0;
   bit       timing_wr     = 1'b0;
   bit       read_seen     = 1'b0;

   always #5 pclk = ~pclk;

   i2c_transfer_sequencer #(.TO_W(TO_W)) dut (
      .pclk              (pclk),
      .preset            (preset),
      .cfg               (cfg),
      .timeout           (timeout),
      .tx_empty          (tx_empty),
      .tx_data           (tx_data),
      .tx_rd_ena         (tx_rd_ena),
      .rx_full           (rx_full),
      .rx_wr_ena         (rx_wr_ena),
      .rx_wdata          (rx_wdata),
      .eng_cmd           (eng_cmd),
      .eng_wdata         (eng_wdata),
      .eng_valid         (eng_valid),
      .eng_ready         (eng_ready),
      .eng_done          (eng_done),
      .eng_ack           (eng_ack),
      .eng_rdata         (eng_rdata),
      .busy              (busy),
      .error             (error),
      .response_ack_nack (response_ack_nack),
      .current_data_tx   (current_data_tx)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic sync_tx();
      tx_empty = (tx_q.size() == 0);
      tx_data  = tx_empty ? 32'hDEADBEEF : {24'hFFFFFF, tx_q[0]};
   endtask

   task automatic push_cmd(input logic [2:0] c, input logic [7:0] d);
      exp_cmd_q.push_back({c, d});
   endtask

   task automatic run_xfer(input logic [13:0] c, input int budget);
      int  n;
      bit  seen;
      cfg = c & 14'h1FFF;
      @(negedge pclk);
      cfg  = c | 14'h2000;
      seen = 1'b0;
      n    = 0;
      while (n < budget && !(seen && !busy)) begin
         @(negedge pclk);
         if (busy) seen = 1'b1;
         n++;
      end
      if (!(seen && !busy)) begin
         checks++;
         errors++;
         $display("FAIL xfer_complete: busy=%0d seen=%0d after %0d cycles, required idle", busy, seen, n);
      end
   endtask

   // Engine responder and scoreboard monitor.
   initial begin
      logic [10:0] e;
      eng_ready = 1'b1;
      eng_done  = 1'b0;
      eng_ack   = 1'b0;
      eng_rdata = 8'd0;
      forever begin
         @(negedge pclk);
         cyc++;
         eng_done = 1'b0;
         if (preset) pend_cnt = 0;
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0 && !(withhold_data && pend_cmd == CMD_WRITE && !pend_is_addr)) begin
               eng_done  = 1'b1;
               eng_ack   = !(nack_addr && pend_is_addr);
               eng_rdata = 8'h00;
               if (pend_cmd == CMD_READ_ACK || pend_cmd == CMD_READ_NACK) begin
                  if (rd_q.size() > 0) eng_rdata = rd_q.pop_front();
                  rd_fire_cyc = cyc;
               end
            end
         end
         if (hold_full && rx_full && cyc == rd_fire_cyc + 6) rx_full = 1'b0;

         if (timing_wr) begin
            if (error) begin
               chk("timeout_wait_cycles", wait_cyc, 20);
               timing_wr = 1'b0;
            end else begin
               wait_cyc++;
            end
         end

         if (eng_valid && eng_ready && !preset) begin
            if (exp_cmd_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_cmd: got cmd=%0d wdata=0x%0h expected none", eng_cmd, eng_wdata);
            end else begin
               e = exp_cmd_q.pop_front();
               chk("eng_cmd", {29'd0, eng_cmd}, {29'd0, e[10:8]});
               if (e[10:8] == CMD_WRITE) chk("eng_wdata", {24'd0, eng_wdata}, {24'd0, e[7:0]});
            end
            pend_cnt     = 2;
            pend_cmd     = eng_cmd;
            pend_is_addr = addr_phase && (eng_cmd == CMD_WRITE);
            if (eng_cmd == CMD_START) addr_phase = 1'b1;
            else if (eng_cmd == CMD_WRITE) addr_phase = 1'b0;
            if (eng_cmd == CMD_WRITE && !pend_is_addr && withhold_data) begin
               timing_wr = 1'b1;
               wait_cyc  = 1;
            end
            if (eng_cmd == CMD_READ_ACK || eng_cmd == CMD_READ_NACK) read_seen = 1'b1;
         end

         if (rx_wr_ena) begin
            if (exp_rx_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rx_push: got 0x%0h expected none", rx_wdata);
            end else begin
               chk("rx_wdata", {16'd0, rx_wdata}, {16'd0, exp_rx_q.pop_front()});
            end
            chk("rx_push_latency", cyc - rd_fire_cyc, hold_full ? 7 : 2);
         end

         if (tx_rd_ena) begin
            tx_pops++;
            if (tx_q.size() > 0) void'(tx_q.pop_front());
         end
         sync_tx();
      end
   end

   initial begin
      int n;
      preset  = 1'b1;
      cfg     = 14'h2250;
      timeout = '0;
      rx_full = 1'b0;
      sync_tx();
      repeat (3) @(negedge pclk);
      chk("rst_busy", busy, 0);
      chk("rst_eng_valid", eng_valid, 0);
      chk("rst_eng_cmd", eng_cmd, 0);
      chk("rst_tx_rd_ena", tx_rd_ena, 0);
      chk("rst_rx_wr_ena", rx_wr_ena, 0);
      chk("rst_error", error, 0);
      chk("rst_nack", response_ack_nack, 0);
      chk("rst_cur_tx", current_data_tx, 0);
      preset = 1'b0;
      repeat (10) @(negedge pclk);
      chk("no_start_on_held_enable", busy, 0);

      // Write two bytes to 0x50.
      tx_q = '{8'hA5, 8'h3C};
      sync_tx();
      push_cmd(CMD_START, 8'h00);
      push_cmd(CMD_WRITE, 8'hA0);
      push_cmd(CMD_WRITE, 8'hA5);
      push_cmd(CMD_WRITE, 8'h3C);
      push_cmd(CMD_STOP, 8'h00);
      tx_pops = 0;
      run_xfer(14'h2250, 300);
      chk("wr_tx_pops", tx_pops, 2);
      chk("wr_error", error, 0);
      chk("wr_nack", response_ack_nack, 0);
      chk("wr_cur_tx", current_data_tx, 32'h3C);
      chk("wr_cmds_left", exp_cmd_q.size(), 0);

      // Read three bytes from 0x50.
      rd_q = '{8'h11, 8'h22, 8'h33};
      push_cmd(CMD_START, 8'h00);
      push_cmd(CMD_WRITE, 8'hA1);
      push_cmd(CMD_READ_ACK, 8'h00);
      push_cmd(CMD_READ_ACK, 8'h00);
      push_cmd(CMD_READ_NACK, 8'h00);
      push_cmd(CMD_STOP, 8'h00);
      exp_rx_q = '{16'h5011, 16'h5022, 16'h5033};
      tx_pops = 0;
      run_xfer(14'h23D0, 300);
      chk("rd_cmds_left", exp_cmd_q.size(), 0);
      chk("rd_rx_left", exp_rx_q.size(), 0);
      chk("rd_tx_pops", tx_pops, 0);
      chk("rd_error", error, 0);

      // Address NACK.
      nack_addr = 1'b1;
      tx_q = '{8'h77};
      sync_tx();
      push_cmd(CMD_START, 8'h00);
      push_cmd(CMD_WRITE, 8'hA0);
      push_cmd(CMD_STOP, 8'h00);
      tx_pops = 0;
      run_xfer(14'h2250, 300);
      chk("nack_flag", response_ack_nack, 1);
      chk("nack_error", error, 0);
      chk("nack_tx_pops", tx_pops, 0);
      chk("nack_cmds_left", exp_cmd_q.size(), 0);
      nack_addr = 1'b0;
      tx_q.delete();
      sync_tx();

      // Timeout while waiting on a data WRITE.
      timeout       = 14'd20;
      withhold_data = 1'b1;
      tx_q = '{8'h5A};
      sync_tx();
      push_cmd(CMD_START, 8'h00);
      push_cmd(CMD_WRITE, 8'hA0);
      push_cmd(CMD_WRITE, 8'h5A);
      push_cmd(CMD_STOP, 8'h00);
      run_xfer(14'h2150, 300);
      chk("to_error", error, 1);
      chk("to_nack", response_ack_nack, 0);
      chk("to_resolved", timing_wr, 0);
      chk("to_cmds_left", exp_cmd_q.size(), 0);
      chk("to_cur_tx", current_data_tx, 32'h5A);
      withhold_data = 1'b0;
      timeout       = '0;

      // RX FIFO full for five PUSH cycles; also a stale error must clear on start.
      hold_full = 1'b1;
      rx_full   = 1'b1;
      rd_q = '{8'hC7};
      push_cmd(CMD_START, 8'h00);
      push_cmd(CMD_WRITE, 8'h25);
      push_cmd(CMD_READ_NACK, 8'h00);
      push_cmd(CMD_STOP, 8'h00);
      exp_rx_q = '{16'h12C7};
      run_xfer(14'h2192, 300);
      chk("full_rx_left", exp_rx_q.size(), 0);
      chk("full_released", rx_full, 0);
      chk("full_error_cleared", error, 0);
      chk("full_cmds_left", exp_cmd_q.size(), 0);
      hold_full = 1'b0;

      // Reset in the middle of a read.
      rd_q = '{8'h11, 8'h22, 8'h33};
      push_cmd(CMD_START, 8'h00);
      push_cmd(CMD_WRITE, 8'hA1);
      push_cmd(CMD_READ_ACK, 8'h00);
      read_seen = 1'b0;
      cfg = 14'h03D0;
      @(negedge pclk);
      cfg = 14'h23D0;
      n = 0;
      while (!read_seen && n < 100) begin
         @(negedge pclk);
         n++;
      end
      chk("rst_mid_read_reached", read_seen, 1);
      preset = 1'b1;
      @(negedge pclk);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_eng_valid", eng_valid, 0);
      chk("mid_rst_eng_cmd", eng_cmd, 0);
      chk("mid_rst_eng_wdata", eng_wdata, 0);
      chk("mid_rst_rx_wdata", rx_wdata, 0);
      chk("mid_rst_tx_rd_ena", tx_rd_ena, 0);
      chk("mid_rst_rx_wr_ena", rx_wr_ena, 0);
      chk("mid_rst_error", error, 0);
      chk("mid_rst_nack", response_ack_nack, 0);
      chk("mid_rst_cur_tx", current_data_tx, 0);
      preset = 1'b0;
      repeat (20) @(negedge pclk);
      chk("mid_rst_no_restart", busy, 0);
      chk("mid_rst_cmds_left", exp_cmd_q.size(), 0);
      rd_q.delete();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
